player_speed_ctrl: RTL and testbench
====================================

Name: player_speed_ctrl

Overview:
- Per-frame player car speed generator for the racing game.
- Takes driver accelerate/brake keys, crash and fuel-empty events, and produces the 10-bit player_speed.
- player_speed feeds the distance accumulator in the game controller and the scrolling logic.
- Speed updates only on startOfFrame (30 Hz); a crash forces speed to 0 immediately and holds it for a fixed number of frames.

Parameters:
- MAX_SPEED, 1000, saturation ceiling for player_speed (must be <= 1023).
- ACCEL_STEP, 4, speed added per frame while accelerating.
- BRAKE_STEP, 16, speed removed per frame while braking.
- DRAG_STEP, 1, speed removed per frame while coasting (no key).
- CRASH_FRAMES, 60, frames speed is held at 0 after a crash (2 s at 30 Hz).

Ports:
- clk  in  1  system clock.
- reset  in  1  synchronous, active-high reset.
- startOfFrame  in  1  one-cycle pulse at start of each frame.
- accel_key  in  1  level, accelerate pressed.
- brake_key  in  1  level, brake pressed.
- crash  in  1  one-cycle pulse from collision detection, any cycle.
- fuel_empty  in  1  level, fuel exhausted.
- player_speed  out  10  current speed, 0..MAX_SPEED, registered.
- crashed  out  1  high while in CRASH state.
- speed_state  out  2  0=IDLE, 1=DRIVE, 2=CRASH.

Behaviour:
- Clock and reset: all logic on posedge clk. reset sampled synchronously, overrides every other input.
- Reset values: player_speed=0, crashed=0, speed_state=IDLE, frame counter=0.
- States:
  - IDLE: speed is 0. On a startOfFrame with accel_key=1, brake_key=0 and fuel_empty=0, go to DRIVE and apply the accelerate step in the same update, so speed=ACCEL_STEP. Otherwise stay in IDLE.
  - DRIVE: on each startOfFrame evaluate, in priority order:
    1. brake_key=1: speed = max(speed-BRAKE_STEP, 0). Brake wins if both keys are pressed.
    2. accel_key=1 and fuel_empty=0: speed = min(speed+ACCEL_STEP, MAX_SPEED).
    3. Otherwise: speed = max(speed-DRAG_STEP, 0). accel_key with fuel_empty=1 counts as coasting.
    - If the resulting speed is 0, go to IDLE on the same update.
    - Between frame pulses, player_speed is held constant.
  - CRASH:
    - Entered on the cycle after crash=1, from any state. That cycle: player_speed=0, crashed=1, frame counter loaded with CRASH_FRAMES.
    - Each startOfFrame decrements the counter. On the startOfFrame that takes the counter from 1 to 0, go to IDLE and set crashed=0.
    - Keys are ignored in CRASH.
    - A crash pulse while in CRASH reloads the counter to CRASH_FRAMES.
- Simultaneous events:
  - crash and startOfFrame in the same cycle: crash wins, and no speed step is applied.
  - reset and crash in the same cycle: reset wins.
- Arithmetic:
  - Use an 11-bit internal sum so the add cannot wrap before clamping.
  - Subtraction saturates at 0 and never underflows.
  - Parameters are unsigned; if ACCEL_STEP > MAX_SPEED, clamp to MAX_SPEED.
- Latency: player_speed changes exactly one cycle after the qualifying startOfFrame or crash pulse, and is stable for the rest of the frame.
- Reset mid-CRASH or mid-DRIVE: next cycle all outputs are at reset values and the counter is cleared.
- startOfFrame asserted on consecutive cycles is treated as two frames; no filtering is required.

Test Plan:
- Reset, then accel_key=1 for 10 frames -> player_speed 4,8,...,40 (one cycle after each pulse); speed_state=DRIVE from frame 1.
- Speed 40, accel and brake both held 3 frames -> 24, 8, 0; speed_state=IDLE after the third pulse.
- Hold accel 260 frames -> speed saturates at 1000, stays 1000, never wraps. Then release for 5 frames -> 999..995.
- Speed 500, crash pulse coincident with startOfFrame -> next cycle speed=0, crashed=1, no step applied. After 60 more pulses crashed=0, state IDLE. A second crash at frame 30 extends the hold to 90 frames in total.
- Speed 200, fuel_empty=1 with accel held 5 frames -> 199..195 (drag only).
- Assert reset while in CRASH with counter=20 -> next cycle speed=0, crashed=0, state IDLE. A subsequent accel frame yields speed 4.

Source files
------------

// File: rtl/player_speed_ctrl.sv
// Per-frame player car speed generator: accelerate/brake/drag stepping on
// each frame pulse, with a crash hold that forces the speed to zero for a
// fixed number of frames.
module player_speed_ctrl #(
    parameter int unsigned MAX_SPEED    = 1000,
    parameter int unsigned ACCEL_STEP   = 4,
    parameter int unsigned BRAKE_STEP   = 16,
    parameter int unsigned DRAG_STEP    = 1,
    parameter int unsigned CRASH_FRAMES = 60
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       startOfFrame,
    input  logic       accel_key,
    input  logic       brake_key,
    input  logic       crash,
    input  logic       fuel_empty,
    output logic [9:0] player_speed,
    output logic       crashed,
    output logic [1:0] speed_state
);

    localparam int unsigned SPEED_W = 10;
    localparam int unsigned SUM_W   = 11;
    localparam int unsigned CNT_W   = (CRASH_FRAMES < 2) ? 1 : $clog2(CRASH_FRAMES + 1);

    // An accelerate step larger than the ceiling is clamped to the ceiling.
    localparam int unsigned ACCEL_EFF = (ACCEL_STEP > MAX_SPEED) ? MAX_SPEED : ACCEL_STEP;
    localparam logic [SUM_W-1:0]   MAX_S   = SUM_W'(MAX_SPEED);
    localparam logic [SUM_W-1:0]   ACCEL_S = SUM_W'(ACCEL_EFF);
    localparam logic [SPEED_W-1:0] ACCEL_FIRST = SPEED_W'(ACCEL_EFF);
    localparam logic [CNT_W-1:0]   CRASH_LOAD  = CNT_W'(CRASH_FRAMES);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_DRIVE = 2'd1,
        S_CRASH = 2'd2
    } state_t;

    state_t             state;
    logic [CNT_W-1:0]   frame_cnt;

    logic [SUM_W-1:0]   accel_sum;
    logic [SPEED_W-1:0] accel_res;
    logic [SPEED_W-1:0] brake_res;
    logic [SPEED_W-1:0] drag_res;
    logic [SPEED_W-1:0] drive_next;

    // Candidate DRIVE speeds: 11-bit add clamped to the ceiling, subtractions saturate at 0.
    always_comb begin
        accel_sum  = {1'b0, player_speed} + ACCEL_S;
        accel_res  = (accel_sum > MAX_S) ? SPEED_W'(MAX_S) : accel_sum[SPEED_W-1:0];
        brake_res  = (32'(player_speed) > BRAKE_STEP) ? (player_speed - SPEED_W'(BRAKE_STEP)) : '0;
        drag_res   = (32'(player_speed) > DRAG_STEP)  ? (player_speed - SPEED_W'(DRAG_STEP))  : '0;
        drive_next = drag_res;
        if (brake_key) begin
            drive_next = brake_res;
        end else if (accel_key && !fuel_empty) begin
            drive_next = accel_res;
        end
    end

    // Speed FSM: reset beats crash, crash beats the frame step.
    always_ff @(posedge clk) begin
        if (reset) begin
            state        <= S_IDLE;
            player_speed <= '0;
            crashed      <= 1'b0;
            frame_cnt    <= '0;
        end else if (crash) begin
            state        <= S_CRASH;
            player_speed <= '0;
            crashed      <= 1'b1;
            frame_cnt    <= CRASH_LOAD;
        end else if (startOfFrame) begin
            case (state)
                S_IDLE: begin
                    if (accel_key && !brake_key && !fuel_empty) begin
                        state        <= S_DRIVE;
                        player_speed <= ACCEL_FIRST;
                    end
                end
                S_DRIVE: begin
                    player_speed <= drive_next;
                    if (drive_next == '0) begin
                        state <= S_IDLE;
                    end
                end
                S_CRASH: begin
                    if (frame_cnt <= CNT_W'(1)) begin
                        state     <= S_IDLE;
                        crashed   <= 1'b0;
                        frame_cnt <= '0;
                    end else begin
                        frame_cnt <= frame_cnt - CNT_W'(1);
                    end
                end
                default: begin
                    state        <= S_IDLE;
                    player_speed <= '0;
                    crashed      <= 1'b0;
                    frame_cnt    <= '0;
                end
            endcase
        end
    end

    assign speed_state = state;

endmodule

// File: tb/tb_player_speed_ctrl.sv
// Directed testbench for player_speed_ctrl.
module tb_player_speed_ctrl;

    logic       clk = 1'b0;
    logic       reset;
    logic       startOfFrame;
    logic       accel_key;
    logic       brake_key;
    logic       crash;
    logic       fuel_empty;
    logic [9:0] player_speed;
    logic       crashed;
    logic [1:0] speed_state;

    int checks = 0;
    int errors = 0;

    player_speed_ctrl dut (
        .clk          (clk),
        .reset        (reset),
        .startOfFrame (startOfFrame),
        .accel_key    (accel_key),
        .brake_key    (brake_key),
        .crash        (crash),
        .fuel_empty   (fuel_empty),
        .player_speed (player_speed),
        .crashed      (crashed),
        .speed_state  (speed_state)
    );

    always #5 clk = ~clk;

    // One frame pulse; outputs are sampled 1 time unit after the capturing edge.
    task automatic pulse_sof();
        @(negedge clk);
        startOfFrame = 1'b1;
        @(posedge clk);
        #1;
        startOfFrame = 1'b0;
    endtask

    task automatic pulse_crash(input logic with_sof);
        @(negedge clk);
        crash        = 1'b1;
        startOfFrame = with_sof;
        @(posedge clk);
        #1;
        crash        = 1'b0;
        startOfFrame = 1'b0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
    endtask

    task automatic idle_cycles(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic check_outs(input string name, input logic [9:0] exp_speed,
                              input logic exp_crashed, input logic [1:0] exp_state);
        // Intentionally unused helper name avoided; comparisons are inline in tests.
    endtask

    task automatic test_reset();
        reset = 1'b1;
        idle_cycles(2);
        reset = 1'b0;
        checks++;
        if (player_speed !== 10'd0 || crashed !== 1'b0 || speed_state !== 2'd0) begin
            errors++;
            $display("FAIL reset: speed=%0d crashed=%0b state=%0d, required 0/0/0",
                     player_speed, crashed, speed_state);
        end
    endtask

    task automatic test_accel();
        accel_key = 1'b1;
        for (int i = 1; i <= 10; i++) begin
            pulse_sof();
            checks++;
            if (player_speed !== 10'(4 * i) || speed_state !== 2'd1) begin
                errors++;
                $display("FAIL accel frame %0d: speed=%0d state=%0d, required %0d/1",
                         i, player_speed, speed_state, 4 * i);
            end
        end
        idle_cycles(3);
        checks++;
        if (player_speed !== 10'd40) begin
            errors++;
            $display("FAIL accel hold: speed=%0d, required 40", player_speed);
        end
    endtask

    task automatic test_both_keys();
        logic [9:0] exp_tab [3];
        exp_tab[0] = 10'd24;
        exp_tab[1] = 10'd8;
        exp_tab[2] = 10'd0;
        accel_key = 1'b1;
        brake_key = 1'b1;
        for (int i = 0; i < 3; i++) begin
            pulse_sof();
            checks++;
            if (player_speed !== exp_tab[i] || speed_state !== ((i == 2) ? 2'd0 : 2'd1)) begin
                errors++;
                $display("FAIL both_keys frame %0d: speed=%0d state=%0d, required %0d/%0d",
                         i, player_speed, speed_state, exp_tab[i], (i == 2) ? 0 : 1);
            end
        end
        brake_key = 1'b0;
        accel_key = 1'b0;
    endtask

    task automatic test_saturate();
        int exp_speed = 0;
        int bad = 0;
        accel_key = 1'b1;
        for (int i = 1; i <= 260; i++) begin
            pulse_sof();
            exp_speed = (exp_speed + 4 > 1000) ? 1000 : exp_speed + 4;
            if (player_speed !== 10'(exp_speed)) begin
                if (bad == 0)
                    $display("FAIL saturate frame %0d: speed=%0d, required %0d",
                             i, player_speed, exp_speed);
                bad++;
            end
        end
        checks++;
        if (bad != 0) errors++;
        checks++;
        if (player_speed !== 10'd1000) begin
            errors++;
            $display("FAIL saturate ceiling: speed=%0d, required 1000", player_speed);
        end
        accel_key = 1'b0;
        for (int i = 1; i <= 5; i++) begin
            pulse_sof();
            checks++;
            if (player_speed !== 10'(1000 - i)) begin
                errors++;
                $display("FAIL coast frame %0d: speed=%0d, required %0d",
                         i, player_speed, 1000 - i);
            end
        end
    endtask

    task automatic test_crash();
        do_reset();
        accel_key = 1'b1;
        repeat (125) pulse_sof();
        checks++;
        if (player_speed !== 10'd500) begin
            errors++;
            $display("FAIL crash setup: speed=%0d, required 500", player_speed);
        end
        // Crash coincident with a frame pulse; accel stays held to show keys are ignored.
        pulse_crash(1'b1);
        checks++;
        if (player_speed !== 10'd0 || crashed !== 1'b1 || speed_state !== 2'd2) begin
            errors++;
            $display("FAIL crash entry: speed=%0d crashed=%0b state=%0d, required 0/1/2",
                     player_speed, crashed, speed_state);
        end
        repeat (59) pulse_sof();
        checks++;
        if (crashed !== 1'b1 || speed_state !== 2'd2 || player_speed !== 10'd0) begin
            errors++;
            $display("FAIL crash hold 59: crashed=%0b state=%0d speed=%0d, required 1/2/0",
                     crashed, speed_state, player_speed);
        end
        pulse_sof();
        checks++;
        if (crashed !== 1'b0 || speed_state !== 2'd0 || player_speed !== 10'd0) begin
            errors++;
            $display("FAIL crash exit 60: crashed=%0b state=%0d speed=%0d, required 0/0/0",
                     crashed, speed_state, player_speed);
        end
        // Standalone crash mid-frame, reloaded after 30 frames: 90 frames in total.
        accel_key = 1'b0;
        pulse_crash(1'b0);
        checks++;
        if (crashed !== 1'b1 || speed_state !== 2'd2) begin
            errors++;
            $display("FAIL crash2 entry: crashed=%0b state=%0d, required 1/2", crashed, speed_state);
        end
        repeat (30) pulse_sof();
        pulse_crash(1'b0);
        repeat (59) pulse_sof();
        checks++;
        if (crashed !== 1'b1 || speed_state !== 2'd2) begin
            errors++;
            $display("FAIL crash reload hold 89: crashed=%0b state=%0d, required 1/2",
                     crashed, speed_state);
        end
        pulse_sof();
        checks++;
        if (crashed !== 1'b0 || speed_state !== 2'd0) begin
            errors++;
            $display("FAIL crash reload exit 90: crashed=%0b state=%0d, required 0/0",
                     crashed, speed_state);
        end
    endtask

    task automatic test_fuel();
        do_reset();
        accel_key  = 1'b1;
        fuel_empty = 1'b1;
        pulse_sof();
        checks++;
        if (player_speed !== 10'd0 || speed_state !== 2'd0) begin
            errors++;
            $display("FAIL fuel idle start: speed=%0d state=%0d, required 0/0",
                     player_speed, speed_state);
        end
        fuel_empty = 1'b0;
        repeat (50) pulse_sof();
        checks++;
        if (player_speed !== 10'd200) begin
            errors++;
            $display("FAIL fuel setup: speed=%0d, required 200", player_speed);
        end
        fuel_empty = 1'b1;
        for (int i = 1; i <= 5; i++) begin
            pulse_sof();
            checks++;
            if (player_speed !== 10'(200 - i)) begin
                errors++;
                $display("FAIL fuel drag frame %0d: speed=%0d, required %0d",
                         i, player_speed, 200 - i);
            end
        end
        fuel_empty = 1'b0;
        accel_key  = 1'b0;
    endtask

    task automatic test_reset_mid_crash();
        pulse_crash(1'b0);
        repeat (40) pulse_sof();
        checks++;
        if (crashed !== 1'b1) begin
            errors++;
            $display("FAIL mid-crash setup: crashed=%0b, required 1", crashed);
        end
        do_reset();
        checks++;
        if (player_speed !== 10'd0 || crashed !== 1'b0 || speed_state !== 2'd0) begin
            errors++;
            $display("FAIL reset mid-crash: speed=%0d crashed=%0b state=%0d, required 0/0/0",
                     player_speed, crashed, speed_state);
        end
        accel_key = 1'b1;
        pulse_sof();
        checks++;
        if (player_speed !== 10'd4 || speed_state !== 2'd1) begin
            errors++;
            $display("FAIL accel after reset: speed=%0d state=%0d, required 4/1",
                     player_speed, speed_state);
        end
    endtask

    task automatic test_reset_and_crash();
        repeat (4) pulse_sof();
        @(negedge clk);
        reset = 1'b1;
        crash = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
        crash = 1'b0;
        checks++;
        if (player_speed !== 10'd0 || crashed !== 1'b0 || speed_state !== 2'd0) begin
            errors++;
            $display("FAIL reset+crash: speed=%0d crashed=%0b state=%0d, required 0/0/0",
                     player_speed, crashed, speed_state);
        end
        accel_key = 1'b0;
    endtask

    initial begin
        reset        = 1'b1;
        startOfFrame = 1'b0;
        accel_key    = 1'b0;
        brake_key    = 1'b0;
        crash        = 1'b0;
        fuel_empty   = 1'b0;
        test_reset();
        test_accel();
        test_both_keys();
        test_saturate();
        test_crash();
        test_fuel();
        test_reset_mid_crash();
        test_reset_and_crash();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
